// File: rtl/fifo_uart_tx_pkg.sv
// fifo_uart_tx_pkg
//   Shared definitions for the FIFO-to-UART transmit path: FSM state
//   encoding, 8N1 frame constants and the bit-period helper.
//   No ports.
package fifo_uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_LATCH = 3'd2,
    ST_START = 3'd3,
    ST_DATA  = 3'd4,
    ST_STOP  = 3'd5
  } tx_state_e;

  localparam int FRAME_BITS = 10;  // start + 8 data + stop
  localparam int DATA_BITS  = 8;

  // Clock cycles per UART bit, truncated.
  function automatic int bit_cycles(input int clk_freq, input int bps);
    return clk_freq / bps;
  endfunction

endpackage

// File: rtl/fifo_uart_tx_baud_cnt.sv
// fifo_uart_tx_baud_cnt
//   Bit-period counter for the UART transmitter. Counts 0..BIT_CYC-1 while
//   enabled and is held at zero while disabled, so every frame starts on a
//   fresh bit period.
// Ports
//   clk_i          system clock
//   rst_ni         asynchronous active-low reset
//   en_i           count enable; clears the counter when low
//   bit_end_o      high while the count is BIT_CYC-1 (last cycle of a bit)
//   bit_pre_end_o  high while the count is BIT_CYC-2, lets the caller
//                  register a pulse that lands on the last cycle of a bit
module fifo_uart_tx_baud_cnt #(
  parameter int BIT_CYC = 434   // must be >= 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic bit_end_o,
  output logic bit_pre_end_o
);

  localparam int CNT_W = (BIT_CYC > 2) ? $clog2(BIT_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(BIT_CYC - 2);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_end_o     = en_i && (cnt_q == LAST);
  assign bit_pre_end_o = en_i && (cnt_q == PRE_LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
//   Drains a standard-read (non-FWFT) synchronous FIFO and sends each byte
//   as an 8N1 UART frame, LSB first. Frames run back to back while the FIFO
//   is non-empty; fifo_empty is only looked at between frames.
// Ports
//   sys_clk       system clock, rising edge
//   sys_rst_n     asynchronous active-low reset
//   fifo_empty    FIFO empty flag
//   fifo_rd_data  FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en    one-cycle read strobe (registered)
//   uart_txd      serial line, idles high (registered)
//   tx_busy       high from the read strobe until the stop bit ends
//   tx_done       one-cycle pulse on the last cycle of the stop bit
//
// state    | meaning
// ---------+------------------------------------------------------
// ST_IDLE  | line high, waiting for a non-empty FIFO
// ST_RD    | read strobe high for this single cycle
// ST_LATCH | FIFO data valid, load shift register, drive start bit
// ST_START | start bit (low) for one bit period
// ST_DATA  | data bits 0..7, LSB first, one bit period each
// ST_STOP  | stop bit (high); tx_done on its last cycle
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int UART_BPS = 115_200,
  parameter int DATA_W   = 8          // only 8 is supported
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              fifo_rd_en,
  output logic              uart_txd,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int BIT_CYC = bit_cycles(CLK_FREQ, UART_BPS);

  tx_state_e         state_q;
  logic [DATA_W-1:0] shift_q;
  logic [2:0]        bit_idx_q;
  logic              rd_en_q;
  logic              txd_q;
  logic              busy_q;
  logic              done_q;

  logic baud_en;
  logic bit_end;
  logic bit_pre_end;

  // The counter is cleared through LATCH, so START always begins at zero.
  assign baud_en = (state_q == ST_START) || (state_q == ST_DATA) ||
                   (state_q == ST_STOP);

  fifo_uart_tx_baud_cnt #(
    .BIT_CYC (BIT_CYC)
  ) u_baud_cnt (
    .clk_i         (sys_clk),
    .rst_ni        (sys_rst_n),
    .en_i          (baud_en),
    .bit_end_o     (bit_end),
    .bit_pre_end_o (bit_pre_end)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      rd_en_q   <= 1'b0;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state_q <= ST_RD;
            rd_en_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ST_RD: begin
          state_q <= ST_LATCH;
        end
        ST_LATCH: begin
          shift_q <= fifo_rd_data;
          txd_q   <= 1'b0;
          state_q <= ST_START;
        end
        ST_START: begin
          if (bit_end) begin
            txd_q     <= shift_q[0];
            shift_q   <= shift_q >> 1;
            bit_idx_q <= '0;
            state_q   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (bit_idx_q == 3'd7) begin
              txd_q   <= 1'b1;
              state_q <= ST_STOP;
            end else begin
              txd_q     <= shift_q[0];
              shift_q   <= shift_q >> 1;
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end
        end
        ST_STOP: begin
          // Registered one cycle early so the pulse sits on the final stop cycle.
          if (bit_pre_end) begin
            done_q <= 1'b1;
          end
          if (bit_end) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign fifo_rd_en = rd_en_q;
  assign uart_txd   = txd_q;
  assign tx_busy    = busy_q;
  assign tx_done    = done_q;

endmodule
